// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multiword add/subtract sequencer.
package add_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/adder_16_cin.sv
// Combinational 16-bit adder with carry-in. Carries are resolved per 4-bit
// group from generate/propagate terms; the group carry-out uses group G/P.
module adder_16_cin
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              C_in,
  output logic [WORD_W-1:0] Sum,
  output logic              CO
);

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W:0]   c;

  // Lookahead carries inside each 4-bit group, group carries chained by G/P.
  always_comb begin
    g = A & B;
    p = A ^ B;
    c = '0;
    c[0] = C_in;
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    Sum = p ^ c[WORD_W-1:0];
    CO  = c[WORD_W];
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds or subtracts two WORDS x 16-bit operands through one shared 16-bit
// adder, least-significant word first, carrying between words in a register.
module multiword_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Sub,
  input  logic [WORD_W*WORDS-1:0]   A,
  input  logic [WORD_W*WORDS-1:0]   B,
  output logic [WORD_W*WORDS-1:0]   Sum,
  output logic                      CO,
  output logic                      V,
  output logic                      Busy,
  output logic                      Done
);

  localparam int unsigned N     = WORD_W * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS) + 1;

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      work_q, work_d;
  logic [N-1:0]      sum_q, sum_d;
  logic              co_q, co_d;
  logic              v_q, v_d;

  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b_raw;
  logic [WORD_W-1:0] word_b;
  logic [WORD_W-1:0] add_s;
  logic              add_co;
  logic [N-1:0]      work_merged;
  logic              last_word;

  // Select the current word and merge this cycle's partial sum into the work copy.
  always_comb begin
    word_a      = '0;
    word_b_raw  = '0;
    work_merged = work_q;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        word_a                        = a_q[i*WORD_W +: WORD_W];
        word_b_raw                    = b_q[i*WORD_W +: WORD_W];
        work_merged[i*WORD_W +: WORD_W] = add_s;
      end
    end
    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
    word_b    = sub_q ? ~word_b_raw : word_b_raw;
    last_word = (idx_q == IDX_W'(WORDS - 1));
  end

  adder_16_cin u_adder (
    .A    (word_a),
    .B    (word_b),
    .C_in (carry_q),
    .Sum  (add_s),
    .CO   (add_co)
  );

  // Next-state and Moore output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    co_d    = co_q;
    v_d     = v_q;
    Busy    = (state_q != IDLE);
    Done    = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Sub;
          carry_d = Sub;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d  = work_merged;
        carry_d = add_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_word) begin
          sum_d   = work_merged;
          co_d    = add_co;
          v_d     = (word_a[WORD_W-1] == word_b[WORD_W-1]) &&
                    (add_s[WORD_W-1] != word_a[WORD_W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      v_q     <= v_d;
    end
  end

  assign Sum = sum_q;
  assign CO  = co_q;
  assign V   = v_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with WORDS=4 (64-bit operands).
module tb_multiword_add_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = 16 * WORDS;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Sum;
  logic         CO;
  logic         V;
  logic         Busy;
  logic         Done;

  logic clk_run;
  int   checks;
  int   failures;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .CO    (CO),
    .V     (V),
    .Busy  (Busy),
    .Done  (Done)
  );

  // Clock can be frozen low for the asynchronous reset check.
  always begin
    #5;
    if (clk_run) Clk = ~Clk;
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic [N-1:0] exp_sum;
    logic         exp_co;
    logic         exp_v;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Launch one operation from IDLE at a negedge and watch cycles 1..7 after E0.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                        output int done_at, output int done_cnt, output int busy_cnt);
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    A     = a;
    B     = b;
    Sub   = sub;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A     = {$urandom, $urandom};
    B     = {$urandom, $urandom};
    Sub   = ~sub;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (Busy) busy_cnt++;
      @(negedge Clk);
    end
  endtask

  task automatic op_and_check(input string name, input vec_t v);
    int done_at, done_cnt, busy_cnt;
    run_op(v.a, v.b, v.sub, done_at, done_cnt, busy_cnt);
    check({name, " sum"}, Sum, v.exp_sum);
    check({name, " co"}, N'(CO), N'(v.exp_co));
    check({name, " v"}, N'(V), N'(v.exp_v));
    check({name, " done_cycle"}, N'(done_at), N'(5));
    check({name, " done_pulses"}, N'(done_cnt), N'(1));
    check({name, " busy_cycles"}, N'(busy_cnt), N'(5));
  endtask

  initial begin
    int   dones;
    int   pos[3];
    int   npos;
    vec_t v;

    checks   = 0;
    failures = 0;
    Clk      = 1'b0;
    clk_run  = 1'b1;
    Reset    = 1'b1;
    Start    = 1'b0;
    Sub      = 1'b0;
    A        = '0;
    B        = '0;

    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[6] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{64'h1234, 64'h1234, 1'b1, 64'h0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset sum", Sum, '0);
    check("reset busy", N'(Busy), '0);
    check("reset done", N'(Done), '0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      op_and_check($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset with the clock frozen low
    v = '{64'h1234, 64'h1111, 1'b0, 64'h2345, 1'b0, 1'b0};
    op_and_check("pre_reset", v);
    clk_run = 1'b0;
    #13;
    Reset = 1'b1;
    #1;
    check("frozen reset sum", Sum, '0);
    check("frozen reset co", N'(CO), '0);
    check("frozen reset v", N'(V), '0);
    check("frozen reset busy", N'(Busy), '0);
    check("frozen reset done", N'(Done), '0);
    #5;
    Reset   = 1'b0;
    #3;
    clk_run = 1'b1;
    @(negedge Clk);

    // Start pulsed during ADD must be ignored
    A = 64'h5; B = 64'h7; Sub = 1'b0; Start = 1'b1;
    dones = 0;
    @(negedge Clk);
    Start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (Done) dones++;
      if (cyc == 2) begin
        Start = 1'b1;
        A     = '1;
        B     = '1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    check("ignored start sum", Sum, 64'd12);
    check("ignored start done_pulses", N'(dones), N'(1));
    check("ignored start idle", N'(Busy), '0);

    // Start held high relaunches every WORDS+2 cycles
    A = 64'h1; B = 64'h2; Sub = 1'b0; Start = 1'b1;
    npos = 0;
    @(negedge Clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (Done && npos < 3) begin
        pos[npos] = cyc;
        npos++;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    check("held start pulses", N'(npos), N'(3));
    if (npos == 3) begin
      check("held start first", N'(pos[0]), N'(5));
      check("held start period1", N'(pos[1] - pos[0]), N'(6));
      check("held start period2", N'(pos[2] - pos[1]), N'(6));
    end
    check("held start sum", Sum, 64'd3);
    repeat (8) @(negedge Clk);

    // Reset in the second ADD cycle discards the operation
    A = 64'h1234; B = 64'h1111; Sub = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("mid reset sum", Sum, '0);
    check("mid reset busy", N'(Busy), '0);
    check("mid reset done", N'(Done), '0);
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (Done || Busy) dones++;
      @(negedge Clk);
    end
    check("mid reset no activity", N'(dones), '0);
    check("mid reset sum held", Sum, '0);
    v = '{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0};
    op_and_check("post_reset", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
